// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL bring-up sequencer and its status register.
package pll_ctrl_pkg;

  // Sequencer state encoding; the status register reports these values.
  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_t;

  // Default timing at the 25 MHz board clock.
  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 65536;   // 2.6 ms
  localparam int unsigned DEF_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_CNT_WIDTH      = 17;
  localparam int unsigned DEF_RETRY_WIDTH    = 8;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-high reset.
module sync_2ff (
  input  logic clock_in,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses PLL RST, qualifies LOCK and holds the
// PLL-clocked domain in reset until lock has been stable long enough.
// Runs on the free-running board clock, never on the PLL output.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// PLL_RST    | pll_rst asserted for PLL_RST_CYCLES cycles
// WAIT_LOCK  | PLL released, waiting up to LOCK_TIMEOUT cycles for lock_s
// STABLE     | lock_s must stay high for STABLE_CYCLES cycles
// RUN        | downstream domain out of reset, ready high
module pll_reset_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int unsigned RETRY_WIDTH    = DEF_RETRY_WIDTH
) (
  input  logic                   clock_in,
  input  logic                   reset,
  input  logic                   locked,
  input  logic                   relock_req,
  output logic                   pll_rst,
  output logic                   domain_reset,
  output logic                   ready,
  output logic [1:0]             state,
  output logic [RETRY_WIDTH-1:0] retry_count,
  output logic [RETRY_WIDTH-1:0] loss_count
);

  localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_WIDTH;

  // Every load value must fit the shared counter; reject bad builds early.
  if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 ||
      longint'(PLL_RST_CYCLES) >= CNT_LIMIT ||
      longint'(LOCK_TIMEOUT)   >= CNT_LIMIT ||
      longint'(STABLE_CYCLES)  >= CNT_LIMIT) begin : g_bad_params
    $error("pll_reset_sequencer: timing parameters must be >= 1 and fit CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0]   PLL_RST_LOAD = CNT_WIDTH'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   TIMEOUT_LOAD = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0]   STABLE_LOAD  = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [RETRY_WIDTH-1:0] COUNT_ONE    = RETRY_WIDTH'(1);
  localparam logic [RETRY_WIDTH-1:0] COUNT_MAX    = '1;

  seq_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 retry_inc, loss_inc;
  logic                 pll_rst_d, domain_reset_d, ready_d;
  logic                 lock_s;

  // Raw LOCK is asynchronous; this is its only consumer.
  sync_2ff u_lock_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .d        (locked),
    .q        (lock_s)
  );

  // State, shared counter and registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= PLL_RST_LOAD;
      pll_rst      <= 1'b1;
      domain_reset <= 1'b1;
      ready        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pll_rst      <= pll_rst_d;
      domain_reset <= domain_reset_d;
      ready        <= ready_d;
    end
  end

  // Saturating event counters for timeouts and lock losses.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      retry_count <= '0;
      loss_count  <= '0;
    end else begin
      if (retry_inc && retry_count != COUNT_MAX) retry_count <= retry_count + COUNT_ONE;
      if (loss_inc && loss_count != COUNT_MAX)   loss_count  <= loss_count + COUNT_ONE;
    end
  end

  // Next state: relock request beats lock loss / timeout, which beat expiry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q - CNT_ONE;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    if (relock_req && state_q != ST_PLL_RST) begin
      state_d = ST_PLL_RST;
      cnt_d   = PLL_RST_LOAD;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == '0) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = TIMEOUT_LOAD;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = STABLE_LOAD;
          end else if (cnt_q == '0) begin
            retry_inc = 1'b1;
            state_d   = ST_PLL_RST;
            cnt_d     = PLL_RST_LOAD;
          end
        end
        ST_STABLE: begin
          // A dropout here is treated as a glitch: no retry, no loss.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = TIMEOUT_LOAD;
          end else if (cnt_q == '0) begin
            state_d = ST_RUN;
            cnt_d   = cnt_q;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_q;
          if (!lock_s) begin
            loss_inc = 1'b1;
            state_d  = ST_PLL_RST;
            cnt_d    = PLL_RST_LOAD;
          end
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = PLL_RST_LOAD;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so they switch with the state register.
  always_comb begin
    pll_rst_d      = (state_d == ST_PLL_RST);
    domain_reset_d = (state_d != ST_RUN);
    ready_d        = (state_d == ST_RUN);
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with shortened timing parameters.
module tb_pll_reset_sequencer;
  import pll_ctrl_pkg::*;

  localparam int unsigned T_RST = 16;
  localparam int unsigned T_TO  = 40;
  localparam int unsigned T_ST  = 24;

  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  logic       locked = 1'b1;
  logic       relock_req = 1'b0;
  logic       pll_rst, domain_reset, ready;
  logic [1:0] state;
  logic [7:0] retry_count, loss_count;

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES (T_RST),
    .LOCK_TIMEOUT   (T_TO),
    .STABLE_CYCLES  (T_ST),
    .CNT_WIDTH      (17),
    .RETRY_WIDTH    (8)
  ) dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .locked       (locked),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .domain_reset (domain_reset),
    .ready        (ready),
    .state        (state),
    .retry_count  (retry_count),
    .loss_count   (loss_count)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic       rst;
    logic       lck;
    logic       rlk;
    int         ncyc;
    logic [1:0] st;
    logic       prst;
    logic       drst;
    logic       rdy;
    logic [7:0] rc;
    logic [7:0] lc;
  } vec_t;

  vec_t vecs[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  task automatic add(input logic rst, input logic lck, input logic rlk, input int n,
                     input logic [1:0] st, input logic prst, input logic drst,
                     input logic rdy, input logic [7:0] rc, input logic [7:0] lc);
    vec_t v;
    v = '{rst, lck, rlk, n, st, prst, drst, rdy, rc, lc};
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string name, input logic [1:0] st, input logic prst,
                            input logic drst, input logic rdy, input logic [7:0] rc,
                            input logic [7:0] lc);
    checks++;
    if ({state, pll_rst, domain_reset, ready, retry_count, loss_count} !==
        {st, prst, drst, rdy, rc, lc}) begin
      errors++;
      $display("FAIL %s got state=%0d pll_rst=%0b domain_reset=%0b ready=%0b retry=%0d loss=%0d, expected state=%0d pll_rst=%0b domain_reset=%0b ready=%0b retry=%0d loss=%0d",
               name, state, pll_rst, domain_reset, ready, retry_count, loss_count,
               st, prst, drst, rdy, rc, lc);
    end
  endtask

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (state !== s) begin
      errors++;
      $display("FAIL %s timed out: state=%0d expected %0d within %0d cycles", name, state, s, budget);
    end
  endtask

  initial begin
    int exp_cnt;

    // reset, lock, inputs held for ncyc cycles, then expected outputs
    //   st: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN
    // Bring-up with lock constantly high
    add(1,1,0, 2,  0,1,1,0, 0,0);
    add(0,1,0,15,  0,1,1,0, 0,0);
    add(0,1,0, 1,  1,0,1,0, 0,0);   // 16th cycle leaves PLL_RST
    add(0,1,0, 1,  2,0,1,0, 0,0);   // lock_s already settled
    add(0,1,0,23,  2,0,1,0, 0,0);
    add(0,1,0, 1,  3,0,0,1, 0,0);   // release after 24 STABLE cycles
    // Lock loss in RUN: seen 3 cycles after the drop
    add(0,0,0, 2,  3,0,0,1, 0,0);
    add(0,0,0, 1,  0,1,1,0, 0,1);
    add(0,0,0,15,  0,1,1,0, 0,1);
    add(0,0,0, 1,  1,0,1,0, 0,1);
    // Timeout in WAIT_LOCK
    add(0,0,0,39,  1,0,1,0, 0,1);
    add(0,0,0, 1,  0,1,1,0, 1,1);
    add(0,1,0,16,  1,0,1,0, 1,1);
    add(0,1,0, 1,  2,0,1,0, 1,1);
    // 3-cycle glitch in STABLE
    add(0,1,0,10,  2,0,1,0, 1,1);
    add(0,0,0, 3,  1,0,1,0, 1,1);
    add(0,1,0, 2,  1,0,1,0, 1,1);
    add(0,1,0, 1,  2,0,1,0, 1,1);
    add(0,1,0,23,  2,0,1,0, 1,1);
    add(0,1,0, 1,  3,0,0,1, 1,1);
    // relock_req together with lock loss in RUN: no loss counted
    add(0,0,0, 2,  3,0,0,1, 1,1);
    add(0,0,1, 1,  0,1,1,0, 1,1);
    // relock_req during PLL_RST does not restart the count
    add(0,0,0, 5,  0,1,1,0, 1,1);
    add(0,0,1, 1,  0,1,1,0, 1,1);
    add(0,0,0, 9,  0,1,1,0, 1,1);
    add(0,0,0, 1,  1,0,1,0, 1,1);
    // relock_req in WAIT_LOCK, STABLE and RUN
    add(0,0,1, 1,  0,1,1,0, 1,1);
    add(0,1,0,16,  1,0,1,0, 1,1);
    add(0,1,0, 1,  2,0,1,0, 1,1);
    add(0,1,1, 1,  0,1,1,0, 1,1);
    add(0,1,0,16,  1,0,1,0, 1,1);
    add(0,1,0, 1,  2,0,1,0, 1,1);
    add(0,1,0,24,  3,0,0,1, 1,1);
    add(0,1,1, 1,  0,1,1,0, 1,1);
    // reset mid-STABLE
    add(0,1,0,16,  1,0,1,0, 1,1);
    add(0,1,0, 1,  2,0,1,0, 1,1);
    add(0,1,0, 5,  2,0,1,0, 1,1);
    add(1,0,0, 1,  0,1,1,0, 0,0);
    // lock_s rising in the same cycle as the timeout: lock wins
    add(0,0,0,16,  1,0,1,0, 0,0);
    add(0,0,0,37,  1,0,1,0, 0,0);
    add(0,1,0, 2,  1,0,1,0, 0,0);
    add(0,1,0, 1,  2,0,1,0, 0,0);
    add(0,1,0,24,  3,0,0,1, 0,0);

    foreach (vecs[i]) begin
      reset      = vecs[i].rst;
      locked     = vecs[i].lck;
      relock_req = vecs[i].rlk;
      tick(vecs[i].ncyc);
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].prst, vecs[i].drst,
                 vecs[i].rdy, vecs[i].rc, vecs[i].lc);
    end
    relock_req = 1'b0;

    // retry_count saturation over 300 timeouts
    reset  = 1'b1;
    locked = 1'b0;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      wait_state(ST_WAIT_LOCK, 40, "sat_enter_wait");
      wait_state(ST_PLL_RST, 60, "sat_timeout");
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      check_val($sformatf("retry_sat%0d", i), int'(retry_count), exp_cnt);
    end

    // loss_count saturation over 260 losses in RUN
    locked = 1'b1;
    wait_state(ST_RUN, 100, "loss_first_run");
    for (int i = 0; i < 260; i++) begin
      locked = 1'b0;
      wait_state(ST_PLL_RST, 5, "loss_detect");
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      check_val($sformatf("loss_sat%0d", i), int'(loss_count), exp_cnt);
      locked = 1'b1;
      wait_state(ST_RUN, 100, "loss_rerun");
    end
    check_val("retry_hold", int'(retry_count), 255);

    // reset mid-STABLE after saturation clears everything next cycle
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    wait_state(ST_STABLE, 40, "final_stable");
    tick(5);
    reset = 1'b1;
    tick(1);
    check_outs("reset_mid_stable", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
